// File: rtl/pacman_pkg.sv
// Shared types for the Pac-Man movement controller: headings, FSM state codes,
// and the neighbour-tile helper that handles maze edges and optional wrap.
package pacman_pkg;

    localparam int TILE_W = 5;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_Q_PEND = 2'd1;
    localparam state_t S_Q_CUR  = 2'd2;
    localparam state_t S_STEP   = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [TILE_W-1:0] x;
        logic [TILE_W-1:0] y;
    } tile_t;

    // valid=0 means the neighbour lies outside the maze and is treated as a wall.
    function automatic tile_t neighbour(
        input logic [TILE_W-1:0] x,
        input logic [TILE_W-1:0] y,
        input dir_t              dir,
        input logic [TILE_W-1:0] x_max,
        input logic [TILE_W-1:0] y_max,
        input logic              tunnel
    );
        tile_t t;
        t.valid = 1'b1;
        t.x     = x;
        t.y     = y;
        case (dir)
            RIGHT: begin
                if (x == x_max) begin
                    t.x     = '0;
                    t.valid = tunnel;
                end else begin
                    t.x = x + 1'b1;
                end
            end
            LEFT: begin
                if (x == '0) begin
                    t.x     = x_max;
                    t.valid = tunnel;
                end else begin
                    t.x = x - 1'b1;
                end
            end
            UP: begin
                if (y == '0) t.valid = 1'b0;
                else         t.y = y - 1'b1;
            end
            default: begin
                if (y == y_max) t.valid = 1'b0;
                else            t.y = y + 1'b1;
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pacman_step_tick.sv
// Movement step timer: counts enabled clocks and pulses o_tick for one cycle
// every TICK_DIV enabled cycles.
module pacman_step_tick #(
    parameter int TICK_DIV = 1666666
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_enable) begin
            if (r_cnt == CNT_MAX) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/pacman_move_ctrl.sv
// Pac-Man tile movement sequencer: buffers turn requests, queries the maze wall
// lookup per step and updates the tile position. Define PACMAN_MOVE_TUNNEL_EN for horizontal wrap.
module pacman_move_ctrl
    import pacman_pkg::*;
#(
    parameter int TICK_DIV = 1666666,
    parameter int MAZE_W   = 28,
    parameter int MAZE_H   = 31,
    parameter int START_X  = 13,
    parameter int START_Y  = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_move_up,
    input  logic              i_move_down,
    input  logic              i_move_left,
    input  logic              i_move_right,
    output logic              o_wall_req,
    output logic [TILE_W-1:0] o_wall_x,
    output logic [TILE_W-1:0] o_wall_y,
    input  logic              i_wall_ack,
    input  logic              i_wall_is_wall,
    output logic [TILE_W-1:0] o_pac_x,
    output logic [TILE_W-1:0] o_pac_y,
    output logic [1:0]        o_pac_dir,
    output logic              o_moving,
    output logic              o_step_done
);

`ifdef PACMAN_MOVE_TUNNEL_EN
    localparam logic TUNNEL = 1'b1;
`else
    localparam logic TUNNEL = 1'b0;
`endif

    localparam logic [TILE_W-1:0] X_MAX   = TILE_W'(MAZE_W - 1);
    localparam logic [TILE_W-1:0] Y_MAX   = TILE_W'(MAZE_H - 1);
    localparam logic [TILE_W-1:0] X_START = TILE_W'(START_X);
    localparam logic [TILE_W-1:0] Y_START = TILE_W'(START_Y);

    state_t            r_state;
    logic [TILE_W-1:0] r_pac_x, r_pac_y;
    dir_t              r_pac_dir, r_pend_dir, r_q_dir;
    logic              r_moving, r_pend_valid, r_tick_pend;
    logic              r_wall_req, r_step_done;
    logic [TILE_W-1:0] r_wall_x, r_wall_y;

    logic  w_tick, w_tick_any, w_key_any, w_decide, w_blocked;
    dir_t  w_key_dir, w_q_dir;
    tile_t w_nb;

    pacman_step_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (i_enable),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_key_dir = RIGHT;
        if (i_move_up)        w_key_dir = UP;
        else if (i_move_down) w_key_dir = DOWN;
        else if (i_move_left) w_key_dir = LEFT;
    end

    assign w_key_any  = i_move_up | i_move_down | i_move_left | i_move_right;
    assign w_tick_any = w_tick | r_tick_pend;
    assign w_q_dir    = (r_state == S_Q_PEND) ? r_pend_dir : r_pac_dir;
    assign w_nb       = neighbour(r_pac_x, r_pac_y, w_q_dir, X_MAX, Y_MAX, TUNNEL);

    // A query state resolves either at once (off-maze target) or on the ack.
    assign w_decide  = r_wall_req ? i_wall_ack : ~w_nb.valid;
    assign w_blocked = ~r_wall_req | i_wall_is_wall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pac_x      <= X_START;
            r_pac_y      <= Y_START;
            r_pac_dir    <= LEFT;
            r_pend_dir   <= LEFT;
            r_q_dir      <= LEFT;
            r_moving     <= 1'b0;
            r_pend_valid <= 1'b0;
            r_tick_pend  <= 1'b0;
            r_wall_req   <= 1'b0;
            r_wall_x     <= '0;
            r_wall_y     <= '0;
            r_step_done  <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            if (w_tick && (r_state != S_IDLE)) r_tick_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_tick_any) begin
                        r_tick_pend <= 1'b0;
                        if (r_pend_valid)  r_state <= S_Q_PEND;
                        else if (r_moving) r_state <= S_Q_CUR;
                    end
                end
                S_Q_PEND, S_Q_CUR: begin
                    if (!r_wall_req && w_nb.valid) begin
                        r_wall_req <= 1'b1;
                        r_wall_x   <= w_nb.x;
                        r_wall_y   <= w_nb.y;
                        r_q_dir    <= w_q_dir;
                    end
                    if (r_wall_req && i_wall_ack) r_wall_req <= 1'b0;
                    if (w_decide) begin
                        if (w_blocked) begin
                            if (r_state == S_Q_PEND) begin
                                r_state <= r_moving ? S_Q_CUR : S_IDLE;
                            end else begin
                                r_moving <= 1'b0;
                                r_state  <= S_IDLE;
                            end
                        end else begin
                            if (r_state == S_Q_PEND) begin
                                r_pac_dir    <= r_q_dir;
                                r_pend_valid <= 1'b0;
                                r_moving     <= 1'b1;
                            end
                            r_state <= S_STEP;
                        end
                    end
                end
                default: begin
                    // The last queried tile is the destination of this step.
                    r_pac_x     <= r_wall_x;
                    r_pac_y     <= r_wall_y;
                    r_step_done <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
            // A fresh key press always wins over clearing the taken request.
            if (w_key_any) begin
                r_pend_dir   <= w_key_dir;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign o_wall_req  = r_wall_req;
    assign o_wall_x    = r_wall_x;
    assign o_wall_y    = r_wall_y;
    assign o_pac_x     = r_pac_x;
    assign o_pac_y     = r_pac_y;
    assign o_pac_dir   = r_pac_dir;
    assign o_moving    = r_moving;
    assign o_step_done = r_step_done;

endmodule
